// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light lights FSM: light encodings,
// state codes and a constant max3 helper used to size the dwell timer.
// Latency: n/a (package). Backpressure: n/a.
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    RED    = 2'b10
  } light_t;

  // S_AR/S_BR are only reachable when all-red clearance is built in.
  typedef enum logic [2:0] {
    S_AG = 3'd0,
    S_AY = 3'd1,
    S_BG = 3'd2,
    S_BY = 3'd3,
    S_AR = 3'd4,
    S_BR = 3'd5
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell timer: saturating up-counter cleared on the first cycle of each state,
// with green / phase-end compare flags. Flags are combinational from the count.
// Backpressure: none; counts every cycle.
// Ports:
//   i_clk, i_rstn  clock, async active-low reset
//   clr            clear next cycle (state is changing)
//   allred_sel     1 = phase_done compares against the all-red length
//   green_done     count >= MIN_GREEN_CYCLES-1
//   phase_done     count == YELLOW_CYCLES-1 (or ALLRED_CYCLES-1 when allred_sel)
module dwell_timer
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN_CYCLES = 8,
  parameter int YELLOW_CYCLES    = 5,
  parameter int ALLRED_CYCLES    = 2
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic clr,
  input  logic allred_sel,
  output logic green_done,
  output logic phase_done
);

  localparam int TW = $clog2(max3(MIN_GREEN_CYCLES, YELLOW_CYCLES, ALLRED_CYCLES)) + 1;

  localparam logic [TW-1:0] GREEN_LAST  = TW'(MIN_GREEN_CYCLES - 1);
  localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_CYCLES - 1);
  localparam logic [TW-1:0] ALLRED_LAST = TW'(ALLRED_CYCLES - 1);

  logic [TW-1:0] cnt;

  // Holding at all-ones keeps an indefinitely long green from wrapping
  // back below the minimum-green threshold.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + TW'(1);
    end
  end

  assign green_done = (cnt >= GREEN_LAST);
  assign phase_done = allred_sel ? (cnt == ALLRED_LAST) : (cnt == YELLOW_LAST);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Lights FSM for streets A and B with min-green, fixed yellow and parade preemption.
// Latency: Moore outputs decoded from the state register; transitions one edge after the condition.
// Backpressure: none; i_M is a level input, no handshake.
// Build option: define TRAFFIC_ALLRED_EN to insert an all-red clearance after each yellow.
// Ports:
//   i_clk, i_rstn   clock (rising edge), async active-low reset
//   i_TA, i_TB      traffic present on street A / B
//   i_M             parade mode (1 = hold B green, preempt A)
//   o_LA, o_LB      lights: 00 GREEN, 01 YELLOW, 10 RED
//   o_state         current state code
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN_CYCLES = 8,
  parameter int YELLOW_CYCLES    = 5,
  parameter int ALLRED_CYCLES    = 2
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_TA,
  input  logic       i_TB,
  input  logic       i_M,
  output logic [1:0] o_LA,
  output logic [1:0] o_LB,
  output logic [2:0] o_state
);

  state_t state, state_nxt;
  light_t la, lb;
  logic   green_done, phase_done;
  logic   timer_clr, allred_sel;

  // Clearing on any state change makes the count read 0 on the first
  // cycle of the new state.
  assign timer_clr  = (state_nxt != state);
  assign allred_sel = (state == S_AR) || (state == S_BR);

  dwell_timer #(
    .MIN_GREEN_CYCLES(MIN_GREEN_CYCLES),
    .YELLOW_CYCLES   (YELLOW_CYCLES),
    .ALLRED_CYCLES   (ALLRED_CYCLES)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .clr       (timer_clr),
    .allred_sel(allred_sel),
    .green_done(green_done),
    .phase_done(phase_done)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= S_AG;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    la        = RED;
    lb        = RED;
    case (state)
      S_AG: begin
        la = GREEN;
        // Parade preempts A only once its minimum green has elapsed.
        if (green_done && (!i_TA || i_M)) state_nxt = S_AY;
      end
      S_AY: begin
        la = YELLOW;
`ifdef TRAFFIC_ALLRED_EN
        if (phase_done) state_nxt = S_AR;
`else
        if (phase_done) state_nxt = S_BG;
`endif
      end
      S_BG: begin
        lb = GREEN;
        if (green_done && !i_TB && !i_M) state_nxt = S_BY;
      end
      S_BY: begin
        lb = YELLOW;
`ifdef TRAFFIC_ALLRED_EN
        if (phase_done) state_nxt = S_BR;
`else
        if (phase_done) state_nxt = S_AG;
`endif
      end
`ifdef TRAFFIC_ALLRED_EN
      S_AR: begin
        if (phase_done) state_nxt = S_BG;
      end
      S_BR: begin
        if (phase_done) state_nxt = S_AG;
      end
`endif
      default: begin
        // Unused codes recover to A-green and show A-green meanwhile.
        state_nxt = S_AG;
        la        = GREEN;
        lb        = RED;
      end
    endcase
  end

  assign o_LA    = la;
  assign o_LB    = lb;
  assign o_state = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
`timescale 1ns/1ps
module tb_traffic_light_ctrl;
  import traffic_pkg::*;

  logic       clk;
  logic       rstn;
  logic       ta, tb, m;
  logic [1:0] la, lb;
  logic [2:0] st;

  traffic_light_ctrl dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .i_TA   (ta),
    .i_TB   (tb),
    .i_M    (m),
    .o_LA   (la),
    .o_LB   (lb),
    .o_state(st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic [1:0] la;
    logic [1:0] lb;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic rst_lvl;
  event chk_ev;

  // Expected lights for a state, straight from the output table.
  function automatic exp_t mk(input state_t s, input string nm);
    exp_t e;
    e.st = s;
    e.nm = nm;
    case (s)
      S_AG:    begin e.la = 2'b00; e.lb = 2'b10; end
      S_AY:    begin e.la = 2'b01; e.lb = 2'b10; end
      S_BG:    begin e.la = 2'b10; e.lb = 2'b00; end
      S_BY:    begin e.la = 2'b10; e.lb = 2'b01; end
      default: begin e.la = 2'b10; e.lb = 2'b10; end
    endcase
    return e;
  endfunction

  // Drive inputs at the falling edge; expect state s after the next rising edge.
  task automatic step(input logic ta_v, input logic tb_v, input logic m_v,
                      input state_t s, input string nm);
    @(negedge clk);
    rstn = rst_lvl;
    ta   = ta_v;
    tb   = tb_v;
    m    = m_v;
    q.push_back(mk(s, nm));
  endtask

  task automatic seg(input logic ta_v, input logic tb_v, input logic m_v,
                     input int n, input state_t s, input string nm);
    for (int i = 0; i < n; i++) step(ta_v, tb_v, m_v, s, nm);
  endtask

  // Monitor: compares after each rising edge, or on demand for async events.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (st !== e.st || la !== e.la || lb !== e.lb) begin
          errors++;
          $display("FAIL %s: got state=%0d LA=%0d LB=%0d, want state=%0d LA=%0d LB=%0d",
                   e.nm, st, la, lb, e.st, e.la, e.lb);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_lvl = 1'b0;
    rstn = 1'b0; ta = 1'b1; tb = 1'b0; m = 1'b0;

    // Reset state, then A holds green while traffic keeps arriving on A.
    seg(1, 0, 0, 3, S_AG, "reset");
    rst_lvl = 1'b1;
    seg(1, 0, 0, 50, S_AG, "ta_hold");

    // Fresh reset; A traffic clears at cycle 3, yellow from cycle 8 for 5 cycles.
    rst_lvl = 1'b0;
    seg(1, 1, 0, 2, S_AG, "reset2");
    rst_lvl = 1'b1;
    seg(1, 1, 0, 2, S_AG, "pre_drop");
    seg(0, 1, 0, 5, S_AG, "min_green");
    seg(0, 1, 0, 5, S_AY, "yellow_a");
`ifdef TRAFFIC_ALLRED_EN
    seg(0, 1, 0, 2, S_AR, "allred_a");
`endif

    // Parade holds B green with no B traffic; dropping it releases B at once.
    seg(0, 0, 1, 40, S_BG, "parade_hold");
    seg(1, 0, 0, 5, S_BY, "parade_drop");
`ifdef TRAFFIC_ALLRED_EN
    seg(1, 0, 0, 2, S_BR, "allred_b");
`endif

    // Parade asserted with A traffic: A gets exactly its 8-cycle minimum.
    seg(1, 0, 1, 8, S_AG, "preempt_green");
    seg(1, 0, 1, 5, S_AY, "preempt_yel");
`ifdef TRAFFIC_ALLRED_EN
    seg(1, 0, 1, 2, S_AR, "allred_a2");
`endif
    seg(1, 0, 1, 10, S_BG, "parade_b");

    // Into B yellow, then asynchronous reset mid-yellow.
    seg(0, 0, 0, 2, S_BY, "by_before_rst");
    @(negedge clk);
    #1;
    rstn    = 1'b0;
    rst_lvl = 1'b0;
    q.push_back(mk(S_AG, "async_rst"));
    -> chk_ev;
    seg(0, 1, 0, 2, S_AG, "rst_hold");
    rst_lvl = 1'b1;
    // Full 8-cycle minimum again shows the timer restarted from 0.
    seg(0, 1, 0, 7, S_AG, "timer_restart");
    seg(0, 1, 0, 5, S_AY, "yellow_a2");
`ifdef TRAFFIC_ALLRED_EN
    seg(0, 1, 0, 2, S_AR, "allred_a3");
`endif
    seg(0, 1, 0, 3, S_BG, "bg2");

    // B traffic clears early: B waits out its minimum green.
    seg(0, 0, 0, 5, S_BG, "bg_min");
    seg(0, 0, 0, 5, S_BY, "yellow_b");
`ifdef TRAFFIC_ALLRED_EN
    seg(0, 0, 0, 2, S_BR, "allred_b2");
`endif

    // A traffic glitches low and returns before min green: A stays green.
    seg(1, 0, 0, 1, S_AG, "ag_entry");
    seg(0, 0, 0, 3, S_AG, "ta_glitch");
    seg(1, 0, 0, 10, S_AG, "ta_back");
    // No A traffic and parade together: one transition; parade toggles in yellow ignored.
    seg(0, 1, 1, 1, S_AY, "ta_and_m");
    seg(0, 1, 1, 2, S_AY, "m_yel");
    seg(0, 1, 0, 2, S_AY, "m_drop_yel");
`ifdef TRAFFIC_ALLRED_EN
    seg(0, 1, 0, 2, S_AR, "allred_a4");
`endif
    seg(0, 1, 0, 3, S_BG, "bg3");

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
